// File: rtl/uart_rx_pkg.sv
// Shared encodings and constants for the UART receive timing engine.
// Phase codes are visible on the phase port; state codes are internal to the counter.
package uart_rx_pkg;

    typedef enum logic [2:0] {
        PH_IDLE   = 3'd0,
        PH_START  = 3'd1,
        PH_DATA   = 3'd2,
        PH_PARITY = 3'd3,
        PH_STOP   = 3'd4,
        PH_DONE   = 3'd5
    } phase_e;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StDone = 2'd2,
        StErr  = 2'd3
    } state_e;

    localparam int unsigned PRESCALE_MIN = 4;
    localparam int unsigned DATA_MIN     = 5;

    localparam logic [1:0] SAMP_FIRST  = 2'd0;
    localparam logic [1:0] SAMP_CENTRE = 2'd1;
    localparam logic [1:0] SAMP_LAST   = 2'd2;

endpackage

// File: rtl/uart_rx_phase_decode.sv
// Maps the bit index within a frame onto its frame phase.
// Start bit first, then data bits, an optional parity bit, and stop bits for the rest.
module uart_rx_phase_decode
    import uart_rx_pkg::*;
#(
    parameter int unsigned BIT_CNT_W = 4
) (
    input  logic [BIT_CNT_W-1:0] i_bit_cnt,
    input  logic [3:0]           i_data_len,
    input  logic                 i_par_en,
    output phase_e               o_phase
);

    logic [BIT_CNT_W-1:0] w_data_len;

    assign w_data_len = BIT_CNT_W'(i_data_len);

    always_comb begin
        o_phase = PH_STOP;
        if (i_bit_cnt == '0) begin
            o_phase = PH_START;
        end else if (i_bit_cnt <= w_data_len) begin
            o_phase = PH_DATA;
        end else if (i_par_en && (i_bit_cnt == w_data_len + BIT_CNT_W'(1))) begin
            o_phase = PH_PARITY;
        end
    end

endmodule

// File: rtl/uart_rx_frame_counter.sv
// Oversampling edge / bit counter for the UART receiver with run-time frame format.
// Emits 3-point mid-bit sample strobes, a bit-end strobe and a registered frame-end pulse.
module uart_rx_frame_counter
    import uart_rx_pkg::*;
#(
    parameter int unsigned PRESCALE_W = 6,
    parameter int unsigned MAX_DATA   = 9,
    parameter int unsigned BIT_CNT_W  = 4
) (
    input  logic                  clk,
    input  logic                  rest,
    input  logic                  enable,
    input  logic [PRESCALE_W-1:0] prescale,
    input  logic [3:0]            data_len,
    input  logic                  par_en,
    input  logic                  stop2,
    output logic [PRESCALE_W-1:0] edge_cnt,
    output logic [BIT_CNT_W-1:0]  bit_cnt,
    output logic [2:0]            phase,
    output logic                  samp_strb,
    output logic [1:0]            samp_idx,
    output logic                  bit_end,
    output logic                  frame_end,
    output logic                  cfg_err
);

    state_e                r_state;
    logic [PRESCALE_W-1:0] r_edge_cnt;
    logic [BIT_CNT_W-1:0]  r_bit_cnt;
    logic [PRESCALE_W-1:0] r_prescale;
    logic [3:0]            r_data_len;
    logic                  r_par_en;
    logic                  r_stop2;
    logic                  r_frame_end;
    logic                  r_cfg_err;

    logic                  w_cfg_ok;
    logic                  w_run;
    logic                  w_last_edge;
    logic [BIT_CNT_W-1:0]  w_last_bit;
    logic [PRESCALE_W-1:0] w_centre;
    logic [PRESCALE_W-1:0] w_samp_lo;
    logic [PRESCALE_W-1:0] w_samp_hi;
    logic                  w_samp_hit;
    phase_e                w_run_phase;
    phase_e                w_phase;

    assign w_cfg_ok = (prescale >= PRESCALE_W'(PRESCALE_MIN)) &&
                      (data_len >= 4'(DATA_MIN)) && (data_len <= 4'(MAX_DATA));

    assign w_run       = (r_state == StRun);
    assign w_last_edge = (r_edge_cnt == r_prescale);

    // Index of the final stop bit: N-1 = data_len + parity + stop bits.
    assign w_last_bit = BIT_CNT_W'(r_data_len) + BIT_CNT_W'(r_par_en) +
                        (r_stop2 ? BIT_CNT_W'(2) : BIT_CNT_W'(1));

    assign w_centre   = r_prescale >> 1;
    assign w_samp_lo  = w_centre - PRESCALE_W'(1);
    assign w_samp_hi  = w_centre + PRESCALE_W'(1);
    assign w_samp_hit = w_run && (r_edge_cnt >= w_samp_lo) && (r_edge_cnt <= w_samp_hi);

    uart_rx_phase_decode #(
        .BIT_CNT_W (BIT_CNT_W)
    ) u_phase_decode (
        .i_bit_cnt  (r_bit_cnt),
        .i_data_len (r_data_len),
        .i_par_en   (r_par_en),
        .o_phase    (w_run_phase)
    );

    always_comb begin
        w_phase = PH_IDLE;
        unique case (r_state)
            StRun:   w_phase = w_run_phase;
            StDone:  w_phase = PH_DONE;
            default: w_phase = PH_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rest) begin
        if (!rest) begin
            r_state     <= StIdle;
            r_edge_cnt  <= '0;
            r_bit_cnt   <= '0;
            r_prescale  <= '0;
            r_data_len  <= '0;
            r_par_en    <= 1'b0;
            r_stop2     <= 1'b0;
            r_frame_end <= 1'b0;
            r_cfg_err   <= 1'b0;
        end else begin
            r_frame_end <= 1'b0;
            unique case (r_state)
                StIdle: begin
                    if (enable) begin
                        if (w_cfg_ok) begin
                            r_prescale <= prescale;
                            r_data_len <= data_len;
                            r_par_en   <= par_en;
                            r_stop2    <= stop2;
                            r_edge_cnt <= PRESCALE_W'(1);
                            r_bit_cnt  <= '0;
                            r_state    <= StRun;
                        end else begin
                            r_cfg_err <= 1'b1;
                            r_state   <= StErr;
                        end
                    end
                end
                StRun: begin
                    if (!enable) begin
                        r_edge_cnt <= '0;
                        r_bit_cnt  <= '0;
                        r_state    <= StIdle;
                    end else if (w_last_edge) begin
                        if (r_bit_cnt == w_last_bit) begin
                            r_edge_cnt  <= '0;
                            r_bit_cnt   <= '0;
                            r_frame_end <= 1'b1;
                            r_state     <= StDone;
                        end else begin
                            r_edge_cnt <= PRESCALE_W'(1);
                            r_bit_cnt  <= r_bit_cnt + BIT_CNT_W'(1);
                        end
                    end else begin
                        r_edge_cnt <= r_edge_cnt + PRESCALE_W'(1);
                    end
                end
                StDone: begin
                    if (!enable) begin
                        r_state <= StIdle;
                    end
                end
                StErr: begin
                    if (!enable) begin
                        r_cfg_err <= 1'b0;
                        r_state   <= StIdle;
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    assign edge_cnt  = r_edge_cnt;
    assign bit_cnt   = r_bit_cnt;
    assign phase     = w_phase;
    assign samp_strb = w_samp_hit;
    assign samp_idx  = w_samp_hit ? 2'(r_edge_cnt - w_samp_lo) : SAMP_FIRST;
    assign bit_end   = w_run && w_last_edge;
    assign frame_end = r_frame_end;
    assign cfg_err   = r_cfg_err;

endmodule

// File: tb/tb_uart_rx_frame_counter.sv
// Bench for uart_rx_frame_counter: frame-level reference model checked every cycle,
// directed frames with hand-computed expectations, then randomized frames and aborts.
module tb_uart_rx_frame_counter;

    localparam int PW = 6;
    localparam int BW = 4;

    localparam int MI = 0;
    localparam int MR = 1;
    localparam int MD = 2;
    localparam int ME = 3;

    logic          clk = 1'b0;
    logic          rest = 1'b0;
    logic          enable = 1'b0;
    logic [PW-1:0] prescale = PW'(8);
    logic [3:0]    data_len = 4'd8;
    logic          par_en = 1'b0;
    logic          stop2 = 1'b0;
    logic [PW-1:0] edge_cnt;
    logic [BW-1:0] bit_cnt;
    logic [2:0]    phase;
    logic          samp_strb;
    logic [1:0]    samp_idx;
    logic          bit_end;
    logic          frame_end;
    logic          cfg_err;

    int n_checks = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    uart_rx_frame_counter #(
        .PRESCALE_W (PW),
        .MAX_DATA   (9),
        .BIT_CNT_W  (BW)
    ) dut (
        .clk       (clk),
        .rest      (rest),
        .enable    (enable),
        .prescale  (prescale),
        .data_len  (data_len),
        .par_en    (par_en),
        .stop2     (stop2),
        .edge_cnt  (edge_cnt),
        .bit_cnt   (bit_cnt),
        .phase     (phase),
        .samp_strb (samp_strb),
        .samp_idx  (samp_idx),
        .bit_end   (bit_end),
        .frame_end (frame_end),
        .cfg_err   (cfg_err)
    );

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    // Phase of bit b, read off an explicit list of the frame's bits.
    function automatic int bit_phase(input int b, input int dl, input bit pe, input bit s2);
        int layout[$];
        layout.push_back(1);
        for (int i = 0; i < dl; i++) layout.push_back(2);
        if (pe) layout.push_back(3);
        layout.push_back(4);
        if (s2) layout.push_back(4);
        if (b < layout.size()) return layout[b];
        return 7;
    endfunction

    function automatic int frame_bits(input int dl, input bit pe, input bit s2);
        return 1 + dl + int'(pe) + (s2 ? 2 : 1);
    endfunction

    // Reference model: m_t counts active cycles since the frame started.
    int m_mode, m_t, m_ps, m_dl;
    bit m_pe, m_s2, m_fe, m_err;

    always @(posedge clk or negedge rest) begin
        if (!rest) begin
            m_mode <= MI; m_t <= 0; m_ps <= 0; m_dl <= 0;
            m_pe <= 0; m_s2 <= 0; m_fe <= 0; m_err <= 0;
        end else begin
            m_fe <= 0;
            case (m_mode)
                MI: if (enable) begin
                    if (int'(prescale) >= 4 && int'(data_len) >= 5 && int'(data_len) <= 9) begin
                        m_ps <= int'(prescale); m_dl <= int'(data_len);
                        m_pe <= par_en; m_s2 <= stop2; m_t <= 0; m_mode <= MR;
                    end else begin
                        m_err <= 1; m_mode <= ME;
                    end
                end
                MR: begin
                    if (!enable) m_mode <= MI;
                    else if (m_t == m_ps * frame_bits(m_dl, m_pe, m_s2) - 1) begin
                        m_fe <= 1; m_mode <= MD;
                    end else m_t <= m_t + 1;
                end
                MD: if (!enable) m_mode <= MI;
                default: if (!enable) begin m_err <= 0; m_mode <= MI; end
            endcase
        end
    end

    always @(negedge clk) begin
        int e, b, ph, c, idx;
        bit strb;
        e = 0; b = 0; ph = 0; idx = 0; strb = 0;
        if (m_mode == MR) begin
            e = m_t % m_ps + 1;
            b = m_t / m_ps;
            ph = bit_phase(b, m_dl, m_pe, m_s2);
            c = m_ps / 2;
            strb = (e >= c - 1) && (e <= c + 1);
            idx = strb ? e - (c - 1) : 0;
        end else if (m_mode == MD) begin
            ph = 5;
        end
        chk("edge_cnt", int'(edge_cnt), e);
        chk("bit_cnt", int'(bit_cnt), b);
        chk("phase", int'(phase), ph);
        chk("samp_strb", int'(samp_strb), int'(strb));
        chk("samp_idx", int'(samp_idx), idx);
        chk("bit_end", int'(bit_end), int'(m_mode == MR && e == m_ps));
        chk("frame_end", int'(frame_end), int'(m_fe));
        chk("cfg_err", int'(cfg_err), int'(m_err));
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    int n_be, n_ss, ss_bad, fe_phase;
    int ph_seq[$];

    // Runs one frame from an enable already set; cycle 0 is the first active cycle.
    task automatic measure_frame(input int limit, input int chg_at, input int ss_lo,
                                 output int fe);
        fe = -1; n_be = 0; n_ss = 0; ss_bad = 0; fe_phase = -1;
        ph_seq.delete();
        for (int k = 0; k < limit; k++) begin
            tick(1);
            if (k == chg_at) prescale = PW'(4);
            if (frame_end) begin
                fe = k; fe_phase = int'(phase);
                break;
            end
            if (bit_end) n_be++;
            if (int'(edge_cnt) == 1) ph_seq.push_back(int'(phase));
            if (samp_strb) begin
                n_ss++;
                if (int'(edge_cnt) < ss_lo || int'(edge_cnt) > ss_lo + 2 ||
                    int'(samp_idx) != int'(edge_cnt) - ss_lo) ss_bad++;
            end
        end
    endtask

    task automatic wait_pos(input int b, input int e, output int found);
        found = 0;
        for (int k = 0; k < 400; k++) begin
            tick(1);
            if (int'(bit_cnt) == b && (e < 0 || int'(edge_cnt) == e)) begin
                found = 1;
                break;
            end
        end
    endtask

    initial begin
        int fe, found, cnt;
        int exp_ph[11];
        exp_ph = '{1, 2, 2, 2, 2, 2, 2, 2, 3, 4, 4};

        #7;
        chk("rst_edge_cnt", int'(edge_cnt), 0);
        chk("rst_bit_cnt", int'(bit_cnt), 0);
        chk("rst_phase", int'(phase), 0);
        chk("rst_frame_end", int'(frame_end), 0);
        chk("rst_cfg_err", int'(cfg_err), 0);
        rest = 1'b1;
        tick(2);

        // 8 edges/bit, 8N1: 10 bits, 80 cycles.
        prescale = PW'(8); data_len = 4'd8; par_en = 0; stop2 = 0;
        enable = 1'b1;
        measure_frame(300, -1, 3, fe);
        chk("t1_frame_end_cycle", fe, 80);
        chk("t1_bit_end_count", n_be, 10);
        chk("t1_samp_count", n_ss, 30);
        chk("t1_samp_position_errors", ss_bad, 0);
        enable = 1'b0;
        tick(2);

        // 16 edges/bit, 7 data, parity, 2 stop: 11 bits, 176 cycles.
        prescale = PW'(16); data_len = 4'd7; par_en = 1; stop2 = 1;
        enable = 1'b1;
        measure_frame(400, -1, 7, fe);
        chk("t2_frame_end_cycle", fe, 176);
        chk("t2_phase_seq_len", ph_seq.size(), 11);
        for (int i = 0; i < 11 && i < ph_seq.size(); i++) chk("t2_phase_seq", ph_seq[i], exp_ph[i]);
        chk("t2_done_phase", fe_phase, 5);
        chk("t2_samp_count", n_ss, 33);
        enable = 1'b0;
        tick(2);

        // Abort mid-frame.
        prescale = PW'(8); data_len = 4'd8; par_en = 0; stop2 = 0;
        enable = 1'b1;
        wait_pos(3, 5, found);
        chk("abort_reached", found, 1);
        enable = 1'b0;
        cnt = 0;
        tick(1);
        chk("abort_edge_cnt", int'(edge_cnt), 0);
        chk("abort_bit_cnt", int'(bit_cnt), 0);
        chk("abort_phase", int'(phase), 0);
        for (int k = 0; k < 5; k++) begin
            if (frame_end) cnt++;
            tick(1);
        end
        chk("abort_no_frame_end", cnt, 0);
        enable = 1'b1;
        tick(1);
        chk("restart_edge_cnt", int'(edge_cnt), 1);
        chk("restart_phase", int'(phase), 1);
        enable = 1'b0;
        tick(2);

        // Illegal configurations.
        prescale = PW'(3);
        enable = 1'b1;
        tick(2);
        chk("err_ps_cfg_err", int'(cfg_err), 1);
        chk("err_ps_phase", int'(phase), 0);
        chk("err_ps_edge_cnt", int'(edge_cnt), 0);
        enable = 1'b0;
        tick(1);
        chk("err_ps_cleared", int'(cfg_err), 0);
        prescale = PW'(8); data_len = 4'd10;
        enable = 1'b1;
        tick(2);
        chk("err_dl_cfg_err", int'(cfg_err), 1);
        chk("err_dl_bit_cnt", int'(bit_cnt), 0);
        enable = 1'b0;
        tick(1);
        chk("err_dl_cleared", int'(cfg_err), 0);
        data_len = 4'd8;
        tick(1);

        // Prescale changed mid-frame; then enable held high after the frame.
        enable = 1'b1;
        measure_frame(300, 20, 3, fe);
        chk("chg_frame_end_cycle", fe, 80);
        cnt = 0;
        for (int k = 0; k < 100; k++) begin
            tick(1);
            if (frame_end || edge_cnt != 0) cnt++;
        end
        chk("hold_no_second_frame", cnt, 0);
        chk("hold_phase_done", int'(phase), 5);
        enable = 1'b0;
        tick(1);
        chk("hold_release_phase", int'(phase), 0);
        enable = 1'b1;
        tick(1);
        chk("hold_restart_edge_cnt", int'(edge_cnt), 1);
        enable = 1'b0;
        prescale = PW'(8);
        tick(2);

        // Asynchronous reset mid-frame.
        enable = 1'b1;
        wait_pos(5, -1, found);
        chk("rst_mid_reached", found, 1);
        rest = 1'b0;
        #1;
        chk("rst_mid_edge_cnt", int'(edge_cnt), 0);
        chk("rst_mid_bit_cnt", int'(bit_cnt), 0);
        chk("rst_mid_phase", int'(phase), 0);
        chk("rst_mid_bit_end", int'(bit_end), 0);
        chk("rst_mid_samp_strb", int'(samp_strb), 0);
        chk("rst_mid_frame_end", int'(frame_end), 0);
        tick(1);
        rest = 1'b1;
        measure_frame(300, -1, 3, fe);
        chk("rst_mid_next_frame", fe, 80);
        enable = 1'b0;
        tick(2);

        // Randomized episodes; the per-cycle model does the checking.
        for (int ep = 0; ep < 40; ep++) begin
            int r, len;
            r = int'($urandom_range(0, 9));
            prescale = (r == 0) ? PW'($urandom_range(0, 3)) : PW'($urandom_range(4, 20));
            if (r == 1) data_len = ($urandom_range(0, 1) == 0) ? 4'($urandom_range(0, 4))
                                                               : 4'($urandom_range(10, 15));
            else data_len = 4'($urandom_range(5, 9));
            par_en = 1'($urandom_range(0, 1));
            stop2 = 1'($urandom_range(0, 1));
            enable = 1'b1;
            len = int'($urandom_range(1, 300));
            for (int k = 0; k < len; k++) begin
                tick(1);
                if ($urandom_range(0, 29) == 0) begin
                    prescale = PW'($urandom_range(0, 63));
                    data_len = 4'($urandom_range(0, 15));
                    par_en = 1'($urandom_range(0, 1));
                    stop2 = 1'($urandom_range(0, 1));
                end
                if (r == 2 && k == len / 2) begin
                    rest = 1'b0;
                    #1;
                    rest = 1'b1;
                end
            end
            enable = 1'b0;
            tick(int'($urandom_range(1, 3)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_rx_frame_counter.md
Name: uart_rx_frame_counter

Overview:
- Parametrised timing engine for the UART receiver. It is the successor to the fixed 5-bit edge/bit counter.
- Counts oversampling edges per bit and bits per frame. Tracks frame phase (START/DATA/PARITY/STOP) and emits a 3-point majority-vote sample strobe, a bit-end strobe and a frame-end pulse.
- Frame format (data length, parity, stop bits) is configurable at run time. The block sits between the RX FSM, which drives enable and config, and the sampler/deserializer, which consume the strobes.

Parameters:
- PRESCALE_W, 6, width of prescale and edge_cnt; legal prescale 4..2^PRESCALE_W-1.
- MAX_DATA, 9, maximum data bits per frame.
- BIT_CNT_W, 4, width of bit_cnt; must hold 1+MAX_DATA+1+2.

Ports:
- clk  in  1  system/UART clock
- rest  in  1  asynchronous active-low reset
- enable  in  1  frame in progress (driven by RX FSM); low forces idle
- prescale  in  PRESCALE_W  oversampling edges per bit
- data_len  in  4  data bits per frame, legal 5..MAX_DATA
- par_en  in  1  parity bit present
- stop2  in  1  0 = one stop bit, 1 = two stop bits
- edge_cnt  out  PRESCALE_W  current edge index, 1..prescale when active, else 0
- bit_cnt  out  BIT_CNT_W  current bit index in frame, 0 = start bit
- phase  out  3  0 IDLE, 1 START, 2 DATA, 3 PARITY, 4 STOP, 5 DONE
- samp_strb  out  1  high on the three mid-bit edges
- samp_idx  out  2  0/1/2 = first/centre/last sample; 0 when samp_strb low
- bit_end  out  1  last edge of the current bit
- frame_end  out  1  one-cycle pulse after the last stop bit completes
- cfg_err  out  1  latched config error for the current enable window

Behaviour:
- Reset (rest low, async):
  - edge_cnt=0, bit_cnt=0, phase=IDLE, frame_end=0, cfg_err=0.
  - All latched config is cleared.
  - Combinational outputs are 0 because they decode from the reset state.
- States: IDLE, RUN, DONE, ERR.
  - phase reports START/DATA/PARITY/STOP while in RUN, decoded from bit_cnt.
- IDLE:
  - enable low: stay in IDLE, counters 0.
  - enable high and config legal (prescale>=4, 5<=data_len<=MAX_DATA):
    - latch prescale, data_len, par_en, stop2;
    - edge_cnt<=1, bit_cnt<=0, go to RUN.
    - edge_cnt is therefore 1 in the first cycle after enable rises.
  - enable high and config illegal: cfg_err<=1, go to ERR, counters stay 0.
- RUN:
  - Each cycle with enable high: edge_cnt<=edge_cnt+1.
  - When edge_cnt==prescale_l: edge_cnt<=1, bit_cnt<=bit_cnt+1.
- Frame length: N = 1 + data_len_l + par_en_l + (stop2_l ? 2 : 1).
- Last bit: when edge_cnt==prescale_l and bit_cnt==N-1:
  - edge_cnt<=0, bit_cnt<=0, frame_end<=1 for exactly one cycle;
  - go to DONE.
- Phase decode from bit_cnt:
  - 0 = START
  - 1..data_len_l = DATA
  - data_len_l+1 = PARITY when par_en_l
  - remaining indices = STOP
- bit_end (combinational) = RUN and edge_cnt==prescale_l.
- Sample strobes:
  - c = prescale_l>>1.
  - samp_strb = RUN and edge_cnt in {c-1, c, c+1}.
  - samp_idx = edge_cnt-(c-1).
  - For prescale 8: edges 3, 4, 5. For prescale 5: edges 1, 2, 3.
- DONE:
  - Counters hold 0.
  - enable must go low to return to IDLE; holding it high does not restart a frame.
- ERR:
  - Counters hold 0; cfg_err stays high while enable is high.
  - enable low: cfg_err<=0, go to IDLE.
- enable low in RUN: next cycle edge_cnt=0, bit_cnt=0, phase=IDLE; no frame_end (abort).
- Config inputs are ignored outside the IDLE->RUN transition, so mid-frame changes have no effect.
- Widths:
  - edge_cnt never exceeds prescale_l and does not wrap through 0 in RUN.
  - bit_cnt never exceeds N-1.
- Reset asserted mid-frame: immediate return to reset values, no frame_end.

Decomposition:
- Shared package uart_rx_pkg:
  - phase encodings (PH_IDLE..PH_DONE) and state encodings;
  - constants PRESCALE_MIN=4, DATA_MIN=5;
  - samp_idx encodings.
- One sub-module is natural: uart_rx_phase_decode, a combinational map (bit_cnt, data_len_l, par_en_l) -> phase.
- The counters and FSM stay in the top module.

Test Plan:
- prescale=8, data_len=8, par_en=0, stop2=0, enable held high:
  - N=10; frame_end pulses once, 80 cycles after the first active cycle;
  - bit_end fires 10 times;
  - samp_strb at edge_cnt 3, 4, 5 with samp_idx 0, 1, 2 in every bit.
- prescale=16, data_len=7, par_en=1, stop2=1:
  - N=11; phase sequence START, DATA x7, PARITY, STOP x2, DONE;
  - frame_end after 176 cycles.
- Abort: enable dropped at bit_cnt=3, edge_cnt=5:
  - next cycle edge_cnt=0, bit_cnt=0, phase=IDLE;
  - frame_end never asserts;
  - re-enable starts a fresh frame with edge_cnt=1.
- Config errors:
  - prescale=3 with enable high: cfg_err=1, phase=IDLE output, counters 0;
  - data_len=10 gives the same result;
  - enable low clears cfg_err.
- Mid-frame config change:
  - prescale changed 8->4 at bit_cnt=2: timing stays at 8 edges/bit until frame_end;
  - enable held high after DONE: no second frame until an enable low->high cycle.
- rest pulsed low at bit_cnt=5: all outputs 0 asynchronously and no frame_end; normal frame after release.
